chirp_profile_sequencer: RTL and testbench
==========================================

# chirp_profile_sequencer

Per-pulse chirp parameter scheduler in the `clk_fmc150` domain. It holds a small table of chirp profiles (frequency offset, tuning coefficient, counter max, repeat count) and presents one profile on `chirp_parameters_out` to the DAC chirp generator. The profile advances on each `chirp_done`, which allows frequency-stepped and interleaved pulse trains without register-map traffic between pulses. The block sits between the register map and the chirp generator, beside the pulse controller that issues `chirp_init`.

## Interface
- `NUM_PROFILES`, default 4: number of table entries (power of two, 2..16).
- `PROF_W`, default 2: log2(NUM_PROFILES).
- `clk_fmc150`  in  1: 245.76 MHz clock; all logic is in this domain.
- `aresetn`  in  1: reset, synchronous, active-low; clock `clk_fmc150`.
- `cfg_wr_en`  in  1: table write strobe.
- `cfg_wr_addr`  in  PROF_W: table entry to write.
- `cfg_wr_data`  in  128: write data; [127:112] repeat, [111:96] reserved, [95:64] freq_offset, [63:32] tuning_coef, [31:0] counter_max.
- `cfg_num_profiles`  in  PROF_W+1: active entries in the sequence.
- `seq_enable`  in  1: level; run the sequence while high.
- `chirp_ready`  in  1: level; DAC ready.
- `chirp_active`  in  1: level; high while chirping.
- `chirp_done`  in  1: 1-cycle pulse at the end of a chirp.
- `chirp_parameters_out`  out  128: {32'b0, freq_offset, tuning_coef, counter_max}.
- `params_valid`  out  1: high while `chirp_parameters_out` is stable and armed.
- `profile_idx`  out  PROF_W: index of the presented profile.
- `pulse_count`  out  32: completed chirps since leaving IDLE; wraps.
- `seq_busy`  out  1: high in any state other than IDLE.
- `cfg_error`  out  1: 1-cycle pulse when a write is rejected.

## Operation
- Reset values:
  - Every table entry: repeat=1, freq_offset=32'h0600, tuning_coef=32'h1, counter_max=32'h0fff.
  - `chirp_parameters_out` = {32'b0, 32'h0600, 32'h1, 32'h0fff}.
  - `params_valid`, `profile_idx`, `pulse_count`, `seq_busy` and `cfg_error` are all 0.
- States: IDLE, LOAD, ARMED, RUN, ADVANCE.
- IDLE:
  - When `seq_enable & chirp_ready`, latch N = clamp(`cfg_num_profiles`, 1, NUM_PROFILES), set idx=0, rep=0, clear `pulse_count`, go to LOAD.
  - A value of 0 is treated as 1. Values above NUM_PROFILES are treated as NUM_PROFILES.
- LOAD (1 cycle): register table[idx] into `chirp_parameters_out`, set `profile_idx`=idx, go to ARMED.
- ARMED: `params_valid`=1.
  - On a rising edge of `chirp_active` (registered compare against the previous cycle), go to RUN.
  - If `seq_enable`=0, go to IDLE.
  - Ignore `chirp_done` in this state.
- RUN: `params_valid`=1; on `chirp_done`, go to ADVANCE. `seq_enable` falling here is deferred until ADVANCE, so a chirp is never cut short.
- ADVANCE (1 cycle):
  - Increment `pulse_count`.
  - If `seq_enable`=0, go to IDLE.
  - Otherwise, with R = (repeat==0 ? 1 : repeat): if rep+1 < R, set rep++ and go to ARMED with no reload.
  - Otherwise set rep=0, idx = (idx+1==N) ? 0 : idx+1, and go to LOAD.
- `chirp_parameters_out` changes only in LOAD. It holds its value in IDLE, including after the sequence stops.
- Table writes:
  - Accepted in any state, except a write to the entry at the current idx while not in IDLE. That write is dropped and `cfg_error` pulses for 1 cycle.
  - An accepted write takes effect on the next LOAD of that entry.
- Width rules: the idx compare uses PROF_W+1 bits; rep is 16 bits; `pulse_count` wraps from 32'hFFFF_FFFF to 0.

## Timing
- Start: `seq_enable` sampled high at cycle n (in IDLE) → LOAD at n+1 → `params_valid` and new parameters visible at n+2.
- Advance: `chirp_done` at cycle n (in RUN) → ADVANCE at n+1 → `params_valid` drops at n+1.
  - Repeat: ARMED at n+2.
  - Next profile: LOAD at n+2, ARMED with new parameters at n+3.
- `pulse_count` increments at the ADVANCE→next edge, i.e. it is visible at n+2.
- `cfg_error` is asserted the cycle after the rejected `cfg_wr_en`.
- Reset asserted mid-sequence returns every output to its reset value on the next edge. The table is reinitialised as well.

## Structure
- Shared package `radar_seq_pkg` holds:
  - the state enum;
  - cfg field bit offsets (REPEAT_HI/LO, FOFF, TUNE, CMAX);
  - default constants 32'h0600, 32'h1, 32'h0fff.
- Sub-module `chirp_profile_regfile`: NUM_PROFILES×128 register file with one synchronous write port, one combinational read port, and reset to the defaults. The sequencer FSM, counters and write-guard logic stay in the top.

## Test plan
- Reset, then check outputs: `chirp_parameters_out`={0,0x600,0x1,0xfff}, `params_valid`=0, `seq_busy`=0.
- Load 3 profiles (counter_max 0x100/0x200/0x300, repeat 1), N=3, enable, pulse 7 chirps → `profile_idx` sequence 0,1,2,0,1,2,0 and `pulse_count`=7.
- Profile 0 repeat=3, profile 1 repeat=0, N=2 → idx sequence 0,0,0,1,0 across 5 chirps; parameters do not change between repeats.
- Write to the current idx during RUN → `cfg_error` pulse and entry unchanged. Write to another entry → it appears on that entry's next LOAD.
- Drop `seq_enable` during RUN → the chirp completes, then ADVANCE→IDLE; `pulse_count` is incremented and `params_valid`=0.
- Assert reset while in ARMED with idx=2 → next cycle all outputs are at reset values. Re-enable → idx starts at 0 with default parameters.

Source files
------------

// File: rtl/radar_seq_pkg.sv
// Shared types and constants for the chirp profile sequencer.
// Holds the FSM state enum, table-entry field offsets and reset defaults.
package radar_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ARMED   = 3'd2,
        S_RUN     = 3'd3,
        S_ADVANCE = 3'd4
    } seq_state_t;

    localparam int REPEAT_HI = 127;
    localparam int REPEAT_LO = 112;
    localparam int RSVD_HI   = 111;
    localparam int RSVD_LO   = 96;
    localparam int FOFF_HI   = 95;
    localparam int FOFF_LO   = 64;
    localparam int TUNE_HI   = 63;
    localparam int TUNE_LO   = 32;
    localparam int CMAX_HI   = 31;
    localparam int CMAX_LO   = 0;

    localparam logic [31:0] DEF_FOFF   = 32'h0600;
    localparam logic [31:0] DEF_TUNE   = 32'h1;
    localparam logic [31:0] DEF_CMAX   = 32'h0fff;
    localparam logic [15:0] DEF_REPEAT = 16'd1;

    function automatic logic [127:0] default_entry();
        return {DEF_REPEAT, 16'h0, DEF_FOFF, DEF_TUNE, DEF_CMAX};
    endfunction

endpackage

// File: rtl/chirp_profile_regfile.sv
// Chirp profile table: NUM_PROFILES x 128-bit entries, reset to defaults.
// Ports: clk_fmc150/aresetn, one sync write port (wr_*), one comb read port (rd_*).
module chirp_profile_regfile
    import radar_seq_pkg::*;
#(
    parameter int NUM_PROFILES = 4,
    parameter int PROF_W       = 2
) (
    input  logic              clk_fmc150,
    input  logic              aresetn,
    input  logic              wr_en,
    input  logic [PROF_W-1:0] wr_addr,
    input  logic [127:0]      wr_data,
    input  logic [PROF_W-1:0] rd_addr,
    output logic [127:0]      rd_data
);

    logic [127:0] mem [NUM_PROFILES];

    always_ff @(posedge clk_fmc150) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_PROFILES; i++) begin
                mem[i] <= default_entry();
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/chirp_profile_sequencer.sv
// Per-pulse chirp profile scheduler; steps through the profile table on chirp_done.
// Ports: cfg_* table writes/sequence length, seq/chirp handshakes in, params/status out.
module chirp_profile_sequencer
    import radar_seq_pkg::*;
#(
    parameter int NUM_PROFILES = 4,
    parameter int PROF_W       = 2
) (
    input  logic              clk_fmc150,
    input  logic              aresetn,
    input  logic              cfg_wr_en,
    input  logic [PROF_W-1:0] cfg_wr_addr,
    input  logic [127:0]      cfg_wr_data,
    input  logic [PROF_W:0]   cfg_num_profiles,
    input  logic              seq_enable,
    input  logic              chirp_ready,
    input  logic              chirp_active,
    input  logic              chirp_done,
    output logic [127:0]      chirp_parameters_out,
    output logic              params_valid,
    output logic [PROF_W-1:0] profile_idx,
    output logic [31:0]       pulse_count,
    output logic              seq_busy,
    output logic              cfg_error
);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [PROF_W-1:0] idx;
    logic [PROF_W:0]   n_act;
    logic [PROF_W:0]   n_clamp;
    logic [PROF_W:0]   idx_inc;
    logic [15:0]       rep;
    logic [15:0]       rep_lim;
    logic              active_q;
    logic              rise;
    logic              last_rep;
    logic              wrap;
    logic              wr_reject;
    logic [127:0]      rd_data;
    logic              unused_rsvd;

    chirp_profile_regfile #(
        .NUM_PROFILES (NUM_PROFILES),
        .PROF_W       (PROF_W)
    ) u_regfile (
        .clk_fmc150 (clk_fmc150),
        .aresetn    (aresetn),
        .wr_en      (cfg_wr_en & ~wr_reject),
        .wr_addr    (cfg_wr_addr),
        .wr_data    (cfg_wr_data),
        .rd_addr    (idx),
        .rd_data    (rd_data)
    );

    assign unused_rsvd = ^rd_data[RSVD_HI:RSVD_LO];

    // The entry being played cannot change under the running sequence.
    assign wr_reject = cfg_wr_en && (state != S_IDLE) && (cfg_wr_addr == idx);

    assign rise    = chirp_active & ~active_q;
    assign rep_lim = (rd_data[REPEAT_HI:REPEAT_LO] == 16'd0) ?
                     16'd1 : rd_data[REPEAT_HI:REPEAT_LO];
    assign last_rep = (rep + 16'd1) >= rep_lim;
    assign idx_inc  = {1'b0, idx} + {{PROF_W{1'b0}}, 1'b1};
    assign wrap     = (idx_inc == n_act);

    always_comb begin
        n_clamp = cfg_num_profiles;
        if (cfg_num_profiles == '0) begin
            n_clamp = (PROF_W+1)'(1);
        end else if (cfg_num_profiles > (PROF_W+1)'(NUM_PROFILES)) begin
            n_clamp = (PROF_W+1)'(NUM_PROFILES);
        end
    end

    always_ff @(posedge clk_fmc150) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A started chirp always runs to completion; enable drop is honoured in ADVANCE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (seq_enable && chirp_ready) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_ARMED;
            S_ARMED: begin
                if (rise)             state_nxt = S_RUN;
                else if (!seq_enable) state_nxt = S_IDLE;
            end
            S_RUN:     if (chirp_done) state_nxt = S_ADVANCE;
            S_ADVANCE: begin
                if (!seq_enable)    state_nxt = S_IDLE;
                else if (!last_rep) state_nxt = S_ARMED;
                else                state_nxt = S_LOAD;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        params_valid = (state == S_ARMED) || (state == S_RUN);
        seq_busy     = (state != S_IDLE);
    end

    always_ff @(posedge clk_fmc150) begin
        if (!aresetn) begin
            chirp_parameters_out <= {32'h0, DEF_FOFF, DEF_TUNE, DEF_CMAX};
            profile_idx          <= '0;
            pulse_count          <= 32'h0;
            cfg_error            <= 1'b0;
            active_q             <= 1'b0;
            idx                  <= '0;
            n_act                <= (PROF_W+1)'(1);
            rep                  <= 16'd0;
        end else begin
            active_q  <= chirp_active;
            cfg_error <= wr_reject;
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_LOAD) begin
                        n_act       <= n_clamp;
                        idx         <= '0;
                        rep         <= 16'd0;
                        pulse_count <= 32'h0;
                    end
                end
                S_LOAD: begin
                    chirp_parameters_out <= {32'h0, rd_data[FOFF_HI:CMAX_LO]};
                    profile_idx          <= idx;
                end
                S_ADVANCE: begin
                    pulse_count <= pulse_count + 32'd1;
                    if (seq_enable) begin
                        if (!last_rep) begin
                            rep <= rep + 16'd1;
                        end else begin
                            rep <= 16'd0;
                            idx <= wrap ? '0 : idx_inc[PROF_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chirp_profile_sequencer.sv
// Randomised bench for chirp_profile_sequencer against a per-pulse reference model.
// Drives table writes, sequence starts and chirp handshakes; checks every presented profile.
module tb_chirp_profile_sequencer;

    localparam int NP = 4;
    localparam int PW = 2;

    logic          clk_fmc150 = 1'b0;
    logic          aresetn = 1'b0;
    logic          cfg_wr_en = 1'b0;
    logic [PW-1:0] cfg_wr_addr = '0;
    logic [127:0]  cfg_wr_data = '0;
    logic [PW:0]   cfg_num_profiles = '0;
    logic          seq_enable = 1'b0;
    logic          chirp_ready = 1'b1;
    logic          chirp_active = 1'b0;
    logic          chirp_done = 1'b0;
    logic [127:0]  chirp_parameters_out;
    logic          params_valid;
    logic [PW-1:0] profile_idx;
    logic [31:0]   pulse_count;
    logic          seq_busy;
    logic          cfg_error;

    chirp_profile_sequencer #(
        .NUM_PROFILES (NP),
        .PROF_W       (PW)
    ) dut (
        .clk_fmc150           (clk_fmc150),
        .aresetn              (aresetn),
        .cfg_wr_en            (cfg_wr_en),
        .cfg_wr_addr          (cfg_wr_addr),
        .cfg_wr_data          (cfg_wr_data),
        .cfg_num_profiles     (cfg_num_profiles),
        .seq_enable           (seq_enable),
        .chirp_ready          (chirp_ready),
        .chirp_active         (chirp_active),
        .chirp_done           (chirp_done),
        .chirp_parameters_out (chirp_parameters_out),
        .params_valid         (params_valid),
        .profile_idx          (profile_idx),
        .pulse_count          (pulse_count),
        .seq_busy             (seq_busy),
        .cfg_error            (cfg_error)
    );

    always #5 clk_fmc150 = ~clk_fmc150;

    int checks = 0;
    int failures = 0;

    logic [127:0] mtab [NP];
    int           mn;
    int           midx;
    int           mrep;
    logic [31:0]  mcount;

    localparam logic [127:0] DFLT =
        {16'd1, 16'd0, 32'h0000_0600, 32'h0000_0001, 32'h0000_0fff};

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mparams(input int i);
        return {32'h0, mtab[i][95:0]};
    endfunction

    function automatic logic [127:0] rnd_entry(input int max_rep);
        return {16'($urandom_range(0, max_rep)), 16'($urandom),
                32'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk_fmc150);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) mtab[i] = DFLT;
    endtask

    task automatic wr(input int a, input logic [127:0] d);
        cfg_wr_addr = PW'(a);
        cfg_wr_data = d;
        cfg_wr_en = 1'b1;
        tick();
        cfg_wr_en = 1'b0;
        chk("idle_wr_err", cfg_error, 0);
        mtab[a] = d;
    endtask

    task automatic start(input int n);
        cfg_num_profiles = (PW+1)'(n);
        seq_enable = 1'b1;
        tick();
        chk("start_load_pv", params_valid, 0);
        chk("start_busy", seq_busy, 1);
        tick();
        chk("start_pv", params_valid, 1);
        mn = (n == 0) ? 1 : ((n > NP) ? NP : n);
        midx = 0;
        mrep = 0;
        mcount = 0;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!params_valid && k < 20) begin
            tick();
            k++;
        end
        if (!params_valid) chk("valid_timeout", 0, 1);
    endtask

    // mode 0: plain, 1: write current entry (rejected),
    // 2: write next entry (accepted), 3: drop enable during RUN
    task automatic chirp(input int mode);
        int a;
        int r;
        logic [127:0] d;
        wait_valid();
        chk("idx", profile_idx, midx);
        chk("params", chirp_parameters_out, mparams(midx));
        chk("count", pulse_count, mcount);
        chirp_active = 1'b1;
        tick();
        chk("run_pv", params_valid, 1);
        if (mode == 1) begin
            d = rnd_entry(3);
            cfg_wr_addr = PW'(midx);
            cfg_wr_data = d;
            cfg_wr_en = 1'b1;
            tick();
            cfg_wr_en = 1'b0;
            chk("rej_err", cfg_error, 1);
            tick();
            chk("rej_pulse", cfg_error, 0);
        end else if (mode == 2) begin
            a = (midx + 1) % mn;
            d = rnd_entry(3);
            cfg_wr_addr = PW'(a);
            cfg_wr_data = d;
            cfg_wr_en = 1'b1;
            tick();
            cfg_wr_en = 1'b0;
            chk("acc_err", cfg_error, 0);
            mtab[a] = d;
        end else if (mode == 3) begin
            seq_enable = 1'b0;
        end
        repeat ($urandom_range(0, 4)) tick();
        chk("run_hold", seq_busy, 1);
        chirp_done = 1'b1;
        tick();
        chirp_done = 1'b0;
        chirp_active = 1'b0;
        chk("adv_pv", params_valid, 0);
        chk("adv_busy", seq_busy, 1);
        mcount = mcount + 1;
        if (mode == 3) begin
            tick();
            chk("stop_busy", seq_busy, 0);
            chk("stop_pv", params_valid, 0);
            chk("stop_count", pulse_count, mcount);
            chk("stop_params", chirp_parameters_out, mparams(midx));
            return;
        end
        r = (mtab[midx][127:112] == 16'd0) ? 1 : int'(mtab[midx][127:112]);
        if (mrep + 1 < r) begin
            mrep++;
        end else begin
            mrep = 0;
            midx = (midx + 1 == mn) ? 0 : midx + 1;
        end
    endtask

    task automatic stop();
        wait_valid();
        seq_enable = 1'b0;
        tick();
        chk("stop_idle", seq_busy, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_params"}, chirp_parameters_out, {32'h0, DFLT[95:0]});
        chk({tag, "_pv"}, params_valid, 0);
        chk({tag, "_idx"}, profile_idx, 0);
        chk({tag, "_count"}, pulse_count, 0);
        chk({tag, "_busy"}, seq_busy, 0);
        chk({tag, "_err"}, cfg_error, 0);
    endtask

    initial begin
        int nch;
        int md;
        model_reset();
        tick();
        tick();
        check_reset_outs("rst");
        aresetn = 1'b1;
        tick();
        check_reset_outs("post_rst");

        // three profiles, repeat 1, seven chirps
        for (int i = 0; i < 3; i++) begin
            wr(i, {16'd1, 16'd0, 32'($urandom), 32'($urandom),
                   32'(32'h100 * (i + 1))});
        end
        start(3);
        for (int i = 0; i < 7; i++) chirp(0);
        tick();
        chk("count7", pulse_count, 32'd7);
        stop();

        // repeat handling: entry0 x3, entry1 repeat 0 treated as 1
        wr(0, {16'd3, 16'd0, 32'($urandom), 32'($urandom), 32'h0000_0111});
        wr(1, {16'd0, 16'd0, 32'($urandom), 32'($urandom), 32'h0000_0222});
        start(2);
        for (int i = 0; i < 5; i++) chirp(0);
        stop();

        // write guard during RUN
        start(3);
        chirp(1);
        chirp(2);
        for (int i = 0; i < 4; i++) chirp(0);
        stop();

        // enable dropped mid-chirp
        start(2);
        chirp(0);
        chirp(3);

        // reset while ARMED at idx 2
        for (int i = 0; i < 3; i++) wr(i, rnd_entry(1) | {16'd1, 112'h0});
        for (int i = 0; i < 3; i++) begin
            mtab[i][127:112] = 16'd1;
            wr(i, mtab[i]);
        end
        start(3);
        chirp(0);
        chirp(0);
        wait_valid();
        chk("pre_rst_idx", profile_idx, 2);
        aresetn = 1'b0;
        seq_enable = 1'b0;
        tick();
        check_reset_outs("mid_rst");
        aresetn = 1'b1;
        model_reset();
        start(3);
        chirp(0);
        stop();

        // randomised sequences, including clamped lengths
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 1) == 1) wr(i, rnd_entry(3));
            end
            start($urandom_range(0, 7));
            nch = $urandom_range(4, 10);
            for (int c = 0; c < nch; c++) begin
                md = $urandom_range(0, 2);
                if (md == 2 && mn < 2) md = 0;
                chirp(md);
            end
            if ($urandom_range(0, 1) == 1) chirp(3);
            else stop();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
